// File: rtl/pls_gen_param.sv
// pls_gen_param: step/direction pulse generator for one motor channel.
// A phase accumulator turns SpeedAct into steps. Direction reversals are guarded.
// Define PLS_RAMP_EN to move SpeedAct toward its target by 1 every RAMP_DIV cycles.
// Without it, SpeedAct jumps to its target.
// Ports:
//   Clk, gRst (sync, active high)
//   SpeedCmd, DirCmd, SpeedSet (rising edge loads the command)
//   PosClr (clears PlsCnt)
//   SpeedSetDone (1-cycle acknowledge of a load)
//   Pls_Out (step), Dir_Out (direction)
//   SpeedAct (speed fed to the accumulator)
//   PlsCnt (signed step position)
module pls_gen_param #(
  parameter int ACC_W     = 17,
  parameter int SPD_W     = 8,
  parameter int POS_W     = 18,
  parameter int DIR_SETUP = 16,
  parameter int RAMP_DIV  = 256
) (
  input  logic             Clk,
  input  logic             gRst,
  input  logic [SPD_W-1:0] SpeedCmd,
  input  logic             DirCmd,
  input  logic             SpeedSet,
  input  logic             PosClr,
  output logic             SpeedSetDone,
  output logic             Pls_Out,
  output logic             Dir_Out,
  output logic [SPD_W-1:0] SpeedAct,
  output logic [POS_W-1:0] PlsCnt
);

  if (SPD_W >= ACC_W || DIR_SETUP < 1 || RAMP_DIV < 1) begin : g_param_chk
    $error("pls_gen_param: invalid parameter set");
  end

  localparam int CW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STOP,
    S_DW_PRE,
    S_DW_POST
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           exit_st;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             dir_nxt;
  logic             ss_d;
  logic             cap;
  logic [SPD_W-1:0] SpeedTgt;
  logic             DirTgt;
  logic [SPD_W-1:0] tgt_spd;
  logic [ACC_W-1:0] acc;
  logic             pls_d;
  logic             step;
  logic             dw;
  logic             spd_zero;

  // Command capture
  assign cap = SpeedSet & ~ss_d;

  always_ff @(posedge Clk) begin
    if (gRst) begin
      ss_d         <= 1'b0;
      SpeedSetDone <= 1'b0;
      SpeedTgt     <= '0;
      DirTgt       <= 1'b0;
    end else begin
      ss_d         <= SpeedSet;
      SpeedSetDone <= cap;
      if (cap) begin
        SpeedTgt <= SpeedCmd;
        DirTgt   <= DirCmd;
      end
    end
  end

  // Sequencer
  assign spd_zero = (SpeedAct == '0);
  assign exit_st  = (SpeedTgt != '0) ? S_RUN : S_IDLE;
  assign dw       = (state == S_DW_PRE) || (state == S_DW_POST);

  always_ff @(posedge Clk) begin
    if (gRst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      Dir_Out <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      Dir_Out <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    dir_nxt   = Dir_Out;
    unique case (state)
      S_IDLE: begin
        if (SpeedTgt != '0)
          state_nxt = (DirTgt != Dir_Out) ? S_DW_PRE : S_RUN;
      end
      S_RUN: begin
        if (DirTgt != Dir_Out)
          state_nxt = S_STOP;
        else if (spd_zero && SpeedTgt == '0)
          state_nxt = S_IDLE;
      end
      S_STOP: begin
        if (spd_zero && !Pls_Out)
          state_nxt = S_DW_PRE;
      end
      S_DW_PRE: begin
        if (cnt == CNT_LAST) begin
          // direction may have been commanded back meanwhile
          if (DirTgt != Dir_Out) begin
            dir_nxt   = DirTgt;
            state_nxt = S_DW_POST;
          end else begin
            state_nxt = exit_st;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DW_POST: begin
        if (cnt == CNT_LAST)
          state_nxt = exit_st;
        else
          cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Target follows the state being entered.
  // A start therefore loads speed on the same edge.
  assign tgt_spd = (state_nxt == S_RUN) ? SpeedTgt : '0;

`ifdef PLS_RAMP_EN
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RDIV_LAST = RW'(RAMP_DIV - 1);

  logic [RW-1:0] rdiv;
  logic          rtick;

  assign rtick = (rdiv == RDIV_LAST);

  always_ff @(posedge Clk) begin
    if (gRst) begin
      rdiv     <= '0;
      SpeedAct <= '0;
    end else begin
      if (cap || rtick)
        rdiv <= '0;
      else
        rdiv <= rdiv + 1'b1;
      if (rtick) begin
        if (SpeedAct < tgt_spd)
          SpeedAct <= SpeedAct + 1'b1;
        else if (SpeedAct > tgt_spd)
          SpeedAct <= SpeedAct - 1'b1;
      end
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (gRst)
      SpeedAct <= '0;
    else
      SpeedAct <= tgt_spd;
  end
`endif

  // Phase accumulator and position counter
  assign step = Pls_Out & ~pls_d;

  always_ff @(posedge Clk) begin
    if (gRst) begin
      acc     <= '0;
      Pls_Out <= 1'b0;
      pls_d   <= 1'b0;
      PlsCnt  <= '0;
    end else begin
      if (spd_zero || dw)
        acc <= '0;
      else
        acc <= acc + ACC_W'(SpeedAct);
      // a stop cuts the pulse instead of waiting for a wrap
      Pls_Out <= acc[ACC_W-1] & ~spd_zero & ~dw;
      pls_d   <= Pls_Out;
      if (PosClr)
        PlsCnt <= '0;
      else if (step)
        PlsCnt <= Dir_Out ? PlsCnt + 1'b1 : PlsCnt - 1'b1;
    end
  end

endmodule
